// File: rtl/scoreboard_regfile_pkg.sv
// Shared types for the scoreboarded register file: read-bypass source
// selection used by every read port.
package scoreboard_regfile_pkg;

  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,
    SRC_FAST  = 2'd1,
    SRC_CMP   = 2'd2,
    SRC_ZERO  = 2'd3
  } rd_src_e;

  // Bypass priority: hard-wired zero, then completion, then fast write.
  function automatic rd_src_e pick_src(input logic zero_hit,
                                       input logic cmp_hit,
                                       input logic fast_hit);
    if (zero_hit)      return SRC_ZERO;
    else if (cmp_hit)  return SRC_CMP;
    else if (fast_hit) return SRC_FAST;
    else               return SRC_ARRAY;
  endfunction

endpackage

// File: rtl/scoreboard_regfile_bits.sv
// Busy scoreboard: one pending bit per register, issue acceptance,
// per-port source-busy reporting and the pending-op counter.
module scoreboard_regfile_bits
  import scoreboard_regfile_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ready,
  input  logic              cmp_valid,
  input  logic [AW-1:0]     cmp_addr,
  input  logic [AW-1:0]     wa,
  output logic              busy_cmp,
  output logic              busy_wa,
  output logic [AW:0]       pend_cnt
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            iss_cmp_hit;
  logic            iss_zero;
  logic            iss_acc;
  logic            cmp_clr;

  // A same-cycle completion to the issue target frees the slot for the new op.
  assign iss_cmp_hit = cmp_valid && (cmp_addr == iss_addr);
  assign iss_ready   = ~busy[iss_addr] | iss_cmp_hit;
  assign iss_zero    = (ZERO_R0 != 0) && (iss_addr == '0);
  assign iss_acc     = iss_valid & iss_ready & ~iss_zero;
  assign cmp_clr     = cmp_valid & busy[cmp_addr];
  assign busy_cmp    = busy[cmp_addr];
  assign busy_wa     = busy[wa];

  for (genvar i = 0; i < NRD; i++) begin : g_rd_busy
    logic [AW-1:0] a;
    assign a          = rd_addr[i*AW +: AW];
    assign rd_busy[i] = busy[a] & ~(cmp_valid && (cmp_addr == a));
  end

  // Next busy vector: clear the completing register, then let a new issue set win.
  always_comb begin
    busy_nxt = busy;
    if (cmp_clr) busy_nxt[cmp_addr] = 1'b0;
    if (iss_acc) busy_nxt[iss_addr] = 1'b1;
  end

  // Busy bits and pending count; reset discards every outstanding op.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pend_cnt + {{AW{1'b0}}, iss_acc} - {{AW{1'b0}}, cmp_clr};
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// Architectural register bank with bypassed combinational reads, a fast
// write port, a long-latency completion port and a busy scoreboard.
module scoreboard_regfile
  import scoreboard_regfile_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  input  logic                 cmp_valid,
  input  logic [AW-1:0]        cmp_addr,
  input  logic [WIDTH-1:0]     cmp_data,
  output logic [AW:0]          pend_cnt,
  output logic                 idle,
  output logic                 err
);

  logic [WIDTH-1:0] mem [NREG];
  logic             busy_cmp;
  logic             busy_wa;
  logic             cmp_zero;
  logic             wa_zero;
  logic             wa_cmp_hit;
  logic             cmp_wr;
  logic             fast_wr;
  logic             err_set;

  scoreboard_regfile_bits #(
    .NREG    (NREG),
    .NRD     (NRD),
    .ZERO_R0 (ZERO_R0)
  ) u_bits (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .cmp_valid (cmp_valid),
    .cmp_addr  (cmp_addr),
    .wa        (wa),
    .busy_cmp  (busy_cmp),
    .busy_wa   (busy_wa),
    .pend_cnt  (pend_cnt)
  );

  // Register 0 swallows writes silently when it is hard-wired to zero.
  assign cmp_zero   = (ZERO_R0 != 0) && (cmp_addr == '0);
  assign wa_zero    = (ZERO_R0 != 0) && (wa == '0);
  assign wa_cmp_hit = we && cmp_valid && (wa == cmp_addr);
  assign cmp_wr     = cmp_valid & ~cmp_zero;
  // A pending result is never overwritten by the fast path; collisions lose to the completion.
  assign fast_wr    = we & ~wa_zero & ~busy_wa & ~wa_cmp_hit;
  assign err_set    = (cmp_wr & ~busy_cmp) | (we & ~wa_zero & (busy_wa | wa_cmp_hit));
  assign idle       = (pend_cnt == '0);

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] dat;
    rd_src_e          src;
    assign a   = rd_addr[i*AW +: AW];
    assign src = pick_src((ZERO_R0 != 0) && (a == '0),
                          cmp_valid && (cmp_addr == a),
                          we && (wa == a));
    // Read-port bypass mux.
    always_comb begin
      dat = mem[a];
      unique case (src)
        SRC_ZERO:  dat = '0;
        SRC_CMP:   dat = cmp_data;
        SRC_FAST:  dat = wd;
        default:   dat = mem[a];
      endcase
    end
    assign rd_data[i*WIDTH +: WIDTH] = dat;
  end

  // Register array: completion and fast write commit at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) mem[k] <= '0;
    end else begin
      if (cmp_wr)  mem[cmp_addr] <= cmp_data;
      if (fast_wr) mem[wa]       <= wd;
    end
  end

  // Sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile (WIDTH=32, NREG=32, NRD=2, ZERO_R0=1).
module tb_scoreboard_regfile;
  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic                 iss_valid;
  logic [AW-1:0]        iss_addr;
  logic                 iss_ready;
  logic                 cmp_valid;
  logic [AW-1:0]        cmp_addr;
  logic [WIDTH-1:0]     cmp_data;
  logic [AW:0]          pend_cnt;
  logic                 idle;
  logic                 err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  scoreboard_regfile #(.WIDTH(WIDTH), .NREG(NREG), .NRD(NRD), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
    .cmp_data(cmp_data), .pend_cnt(pend_cnt), .idle(idle), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    we = 1'b0; wa = '0; wd = '0;
    iss_valid = 1'b0; iss_addr = '0;
    cmp_valid = 1'b0; cmp_addr = '0; cmp_data = '0;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_addr = '0;
    do_reset();
    chk("rst_pend", pend_cnt, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    for (int r = 0; r < NREG; r += 2) begin
      rd(r, r + 1);
      chk($sformatf("rst_rd%0d", r), rd_data, 0);
      chk($sformatf("rst_busy%0d", r), rd_busy, 0);
    end

    // Fast write with same-cycle bypass, then from the array.
    we = 1; wa = 5; wd = 32'hDEADBEEF; rd(5, 0);
    chk("wr_bypass", rd_data[31:0], 32'hDEADBEEF);
    tick(); quiet(); rd(5, 0);
    chk("wr_array", rd_data[31:0], 32'hDEADBEEF);
    we = 1; wa = 0; wd = 32'h1234; rd(0, 5);
    chk("r0_bypass", rd_data[31:0], 0);
    tick(); quiet(); rd(0, 5);
    chk("r0_array", rd_data[31:0], 0);
    chk("r0_err", err, 0);

    // Issue r7, wait, then complete it.
    iss_valid = 1; iss_addr = 7; rd(7, 0);
    chk("iss7_ready", iss_ready, 1);
    tick(); quiet(); tick(); tick(); tick(); rd(7, 0);
    chk("r7_busy", rd_busy[0], 1);
    chk("r7_pend", pend_cnt, 1);
    chk("r7_idle", idle, 0);
    cmp_valid = 1; cmp_addr = 7; cmp_data = 32'h3F800000; rd(7, 0);
    chk("cmp7_bypass", rd_data[31:0], 32'h3F800000);
    chk("cmp7_unbusy", rd_busy[0], 0);
    tick(); quiet(); rd(7, 0);
    chk("cmp7_pend", pend_cnt, 0);
    chk("cmp7_array", rd_data[31:0], 32'h3F800000);
    chk("cmp7_err", err, 0);

    // Reissue to busy r7 stalls; issue+completion same cycle keeps it busy.
    iss_valid = 1; iss_addr = 7; tick(); rd(7, 0);
    chk("iss7b_ready", iss_ready, 0);
    tick(); rd(7, 0);
    chk("iss7b_pend", pend_cnt, 1);
    cmp_valid = 1; cmp_addr = 7; cmp_data = 32'h11112222; rd(7, 0);
    chk("isscmp_ready", iss_ready, 1);
    tick(); quiet(); rd(7, 0);
    chk("isscmp_pend", pend_cnt, 1);
    chk("isscmp_busy", rd_busy[0], 1);
    chk("isscmp_data", rd_data[31:0], 32'h11112222);
    chk("isscmp_err", err, 0);
    cmp_valid = 1; cmp_addr = 7; cmp_data = 32'h40000000;
    tick(); quiet(); rd(7, 0);
    chk("r7_final_pend", pend_cnt, 0);
    chk("r7_final_data", rd_data[31:0], 32'h40000000);

    // Fast write to busy r9 is dropped and flags err.
    iss_valid = 1; iss_addr = 9; tick(); quiet();
    we = 1; wa = 9; wd = 32'h1; tick(); quiet(); rd(9, 0);
    chk("r9_keep", rd_data[31:0], 0);
    chk("r9_err", err, 1);
    do_reset(); rd(9, 7);
    chk("rst2_err", err, 0);
    chk("rst2_pend", pend_cnt, 0);
    chk("rst2_r7", rd_data[63:32], 0);
    chk("rst2_busy9", rd_busy[0], 0);

    // Reset drops pending r10; its late completion is unmatched.
    iss_valid = 1; iss_addr = 10; tick(); quiet();
    rst = 1; tick(); rst = 0; rd(10, 0);
    chk("rst3_busy10", rd_busy[0], 0);
    chk("rst3_pend", pend_cnt, 0);
    cmp_valid = 1; cmp_addr = 10; cmp_data = 32'hA0A0; tick(); quiet(); rd(10, 0);
    chk("late_cmp_data", rd_data[31:0], 32'hA0A0);
    chk("late_cmp_err", err, 1);
    do_reset();

    // Completion to non-busy r3.
    cmp_valid = 1; cmp_addr = 3; cmp_data = 32'h33; tick(); quiet(); rd(3, 0);
    chk("r3_data", rd_data[31:0], 32'h33);
    chk("r3_err", err, 1);
    do_reset();

    // Fast write and completion to different registers both commit.
    iss_valid = 1; iss_addr = 14; tick(); quiet();
    we = 1; wa = 13; wd = 32'h1313; cmp_valid = 1; cmp_addr = 14; cmp_data = 32'h1414;
    tick(); quiet(); rd(13, 14);
    chk("dual_r13", rd_data[31:0], 32'h1313);
    chk("dual_r14", rd_data[63:32], 32'h1414);
    chk("dual_err", err, 0);
    // Same register: completion wins and err is raised.
    we = 1; wa = 12; wd = 32'hAAAA; cmp_valid = 1; cmp_addr = 12; cmp_data = 32'hBBBB; rd(12, 0);
    chk("coll_bypass", rd_data[31:0], 32'hBBBB);
    tick(); quiet(); rd(12, 0);
    chk("coll_array", rd_data[31:0], 32'hBBBB);
    chk("coll_err", err, 1);
    do_reset();

    // Register 0: issue is a no-op, completion dropped without err.
    iss_valid = 1; iss_addr = 0; rd(0, 0);
    chk("r0_iss_ready", iss_ready, 1);
    tick(); quiet(); rd(0, 0);
    chk("r0_iss_pend", pend_cnt, 0);
    chk("r0_iss_busy", rd_busy[0], 0);
    cmp_valid = 1; cmp_addr = 0; cmp_data = 32'h77; tick(); quiet(); rd(0, 0);
    chk("r0_cmp_data", rd_data[31:0], 0);
    chk("r0_cmp_err", err, 0);

    // Four outstanding ops completed out of order.
    for (int r = 1; r <= 4; r++) begin
      iss_valid = 1; iss_addr = AW'(r); tick();
      chk($sformatf("multi_iss%0d", r), pend_cnt, r);
    end
    quiet();
    begin
      int order[4] = '{3, 1, 4, 2};
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        e.addr = AW'(order[k]);
        e.data = 32'hC000_0000 + order[k];
        sbq.push_back(e);
        cmp_valid = 1; cmp_addr = e.addr; cmp_data = e.data; tick();
        chk($sformatf("multi_cmp%0d", order[k]), pend_cnt, 3 - k);
      end
    end
    quiet(); rd(0, 0);
    chk("multi_idle", idle, 1);
    chk("multi_err", err, 0);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      rd(int'(e.addr), 0);
      chk($sformatf("sb_r%0d", e.addr), rd_data[31:0], e.data);
      chk($sformatf("sb_busy%0d", e.addr), rd_busy[0], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
